// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin request arbiter.
// Optional ARB_TIMEOUT_EN enables the forced-release hold counter.
package arb_pkg;

  localparam int N_REQ    = 4;
  localparam int ID_W     = 2;
  localparam int MAX_HOLD = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [ID_W-1:0] onehot_to_id(
    input logic [N_REQ-1:0] oh
  );
    logic [ID_W-1:0] id;
    id = '0;
    unique case (1'b1)
      oh[0]:   id = 2'd0;
      oh[1]:   id = 2'd1;
      oh[2]:   id = 2'd2;
      oh[3]:   id = 2'd3;
      default: id = 2'd0;
    endcase
    return id;
  endfunction

endpackage

// File: rtl/rr_req_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
// Timeout output only toggles when ARB_TIMEOUT_EN is defined.
interface rr_req_arbiter_if;
  import arb_pkg::*;

  logic             en;
  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_vld;
  logic             timeout;

  modport master (
    output en, req, done,
    input  gnt, gnt_id, gnt_vld, timeout
  );

  modport slave (
    input  en, req, done,
    output gnt, gnt_id, gnt_vld, timeout
  );

endinterface

// File: rtl/rr_prio_pick.sv
// Rotated priority encoder: lowest request above ptr, else lowest overall.
// Purely combinational; used by rr_req_arbiter for every grant issue.
module rr_prio_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  pick_id,
  output logic             pick_vld
);

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] src;
  logic [N_REQ-1:0] low;

  // Mask off ptr and below, isolate lowest set bit of the chosen vector
  always_comb begin
    mask = '0;
    for (int i = 0; i < N_REQ; i++)
      mask[i] = (i > int'(ptr));
    masked   = req & mask;
    src      = (|masked) ? masked : req;
    low      = src & (~src + 4'd1);
    pick_id  = onehot_to_id(low);
    pick_vld = |req;
  end

endmodule

// File: rtl/rr_req_arbiter.sv
// Four-way round-robin arbiter with grant hold and release handshake.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD grant cycles.
module rr_req_arbiter
  import arb_pkg::*;
(
  input logic            clk,
  input logic            rst,
  rr_req_arbiter_if.slave bus
);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             timeout_q, timeout_d;
  logic [N_REQ-1:0] arb_req;
  logic [ID_W-1:0]  pick_id;
  logic             pick_vld;
  logic             owner_rel;
  logic             force_rel;
  logic             rel;
  logic             issue;

  // Owner releases by done or by withdrawing its request
  assign owner_rel = (state_q == GRANT) &&
                     (bus.done || !bus.req[id_q]);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;

  assign force_rel = (state_q == GRANT) && !owner_rel &&
                     (hold_q == 8'(MAX_HOLD - 1));

  // Hold counter: cleared on issue, counts every GRANT cycle
  always_comb begin
    hold_d = hold_q;
    if (issue)
      hold_d = '0;
    else if (state_q == GRANT)
      hold_d = hold_q + 8'd1;
  end

  // Hold counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`else
  assign force_rel = 1'b0;
`endif

  assign rel = owner_rel | force_rel;

  // The released owner never competes in the same-edge pick
  assign arb_req = (state_q == GRANT) ? (bus.req & ~gnt_q) : bus.req;

  rr_prio_pick u_pick (
    .req      (arb_req),
    .ptr      (ptr_q),
    .pick_id  (pick_id),
    .pick_vld (pick_vld)
  );

  // Next-state and grant decisions
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    issue     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.en && pick_vld)
          issue = 1'b1;
      end
      GRANT: begin
        if (rel) begin
          timeout_d = force_rel;
          if (bus.en && pick_vld) begin
            issue = 1'b1;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      gnt_d   = 4'b0001 << pick_id;
      id_d    = pick_id;
      ptr_d   = pick_id;
      state_d = GRANT;
    end
  end

  // State, pointer and grant registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      id_q      <= '0;
      ptr_q     <= 2'd3;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = id_q;
  assign bus.gnt_vld = |gnt_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed-vector bench for rr_req_arbiter.
// Timeout scenarios run when ARB_TIMEOUT_EN is defined.
module tb_rr_req_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  rr_req_arbiter_if bus ();

  rr_req_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] order [5];

  initial begin
    n_checks = 0;
    n_errors = 0;
    order[0] = 4'b0001;
    order[1] = 4'b0010;
    order[2] = 4'b0100;
    order[3] = 4'b1000;
    order[4] = 4'b0001;
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    tick();
    check("rst_gnt", 8'(bus.gnt), 8'h0);
    check("rst_id", 8'(bus.gnt_id), 8'h0);
    check("rst_vld", 8'(bus.gnt_vld), 8'h0);
    check("rst_to", 8'(bus.timeout), 8'h0);
    rst = 1'b0;

    // 1: full rotation 0,1,2,3,0
    bus.en  = 1'b1;
    bus.req = 4'b1111;
    tick();
    check("rot0", 8'(bus.gnt), 8'(order[0]));
    for (int i = 1; i < 5; i++) begin
      bus.done = 1'b1;
      tick();
      check("rot", 8'(bus.gnt), 8'(order[i]));
      check("rot_vld", 8'(bus.gnt_vld), 8'h1);
    end
    bus.done = 1'b0;

    // 2: owner 0 withdraws -> 2; then done from 2 -> 0 back-to-back
    bus.req = 4'b0100;
    tick();
    check("own2", 8'(bus.gnt), 8'h04);
    check("own2_id", 8'(bus.gnt_id), 8'h2);
    bus.req  = 4'b0101;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("sw_gnt", 8'(bus.gnt), 8'h01);
    check("sw_vld", 8'(bus.gnt_vld), 8'h1);
    check("sw_id", 8'(bus.gnt_id), 8'h0);

    // 3: enable gating
    bus.en  = 1'b0;
    bus.req = 4'b0000;
    tick();
    check("en0_rel", 8'(bus.gnt), 8'h0);
    bus.req = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("en0_hold", 8'(bus.gnt), 8'h0);
    end
    bus.en = 1'b1;
    tick();
    check("en1_gnt", 8'(bus.gnt), 8'h02);
    check("en1_id", 8'(bus.gnt_id), 8'h1);

    // 4: withdraw without done, then stray done in IDLE
    bus.req = 4'b0000;
    tick();
    check("wd_gnt", 8'(bus.gnt), 8'h0);
    check("wd_vld", 8'(bus.gnt_vld), 8'h0);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("idle_done", 8'(bus.gnt), 8'h0);

    // 5: async reset mid-grant, then ptr back at 3
    bus.req = 4'b0010;
    tick();
    check("pre_rst", 8'(bus.gnt), 8'h02);
    #2 rst = 1'b1;
    #1;
    check("async_gnt", 8'(bus.gnt), 8'h0);
    check("async_vld", 8'(bus.gnt_vld), 8'h0);
    bus.req = 4'b0000;
    tick();
    rst = 1'b0;
    bus.req = 4'b1001;
    tick();
    check("ptr3_gnt", 8'(bus.gnt), 8'h01);
    bus.req = 4'b1000;
    tick();
    check("post_rst", 8'(bus.gnt), 8'h08);
    check("post_id", 8'(bus.gnt_id), 8'h3);

`ifdef ARB_TIMEOUT_EN
    // 6: forced release after 8 grant cycles
    bus.req = 4'b1100;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("to_hold", 8'(bus.gnt), 8'h08);
      check("to_low", 8'(bus.timeout), 8'h0);
    end
    tick();
    check("to_gnt", 8'(bus.gnt), 8'h04);
    check("to_pulse", 8'(bus.timeout), 8'h1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("to_h2", 8'(bus.gnt), 8'h04);
      check("to_clr", 8'(bus.timeout), 8'h0);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("dn_wins", 8'(bus.timeout), 8'h0);
    check("dn_gnt", 8'(bus.gnt), 8'h08);
`else
    // 6: no timeout build holds the grant indefinitely
    bus.req = 4'b1100;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold", 8'(bus.gnt), 8'h08);
      check("no_to", 8'(bus.timeout), 8'h0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
